// File: rtl/seq_shifter_if.sv
// seq_shifter_if: operand/request and result bundle for seq_shifter.
// master = operand source / testbench side, slave = shifter side.
//
// Handshake: the source raises start with din/amt/mode valid. The request is
// taken on a rising clk edge only while busy is low, and is otherwise dropped
// without queueing. busy is high from the edge after acceptance until the
// shifter returns to IDLE. done pulses for exactly one cycle when dout/carry
// hold the final result. state exposes the FSM encoding for observation.
interface seq_shifter_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             serial_in;
  logic [WIDTH-1:0] dout;
  logic             carry;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, mode, amt, din, serial_in,
    input  dout, carry, busy, done, state
  );

  modport slave (
    input  start, mode, amt, din, serial_in,
    output dout, carry, busy, done, state
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: registered multi-cycle shifter/rotator, one 1-bit step per clock.
// Optional feature macro: SEQ_SHIFTER_ARITH_EN enables mode 100 as an
// arithmetic right shift; without it mode 100 holds like modes 101-111.
module seq_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, step_dout;
  logic             carry_q, step_carry;
  logic [AMT_W-1:0] count_q;
  logic [2:0]       mode_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only counts in IDLE; zero amount skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.amt != '0) ? SHIFT : DONE;
      SHIFT:   if (count_q == AMT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One step of the latched operation; serial_in is used live, not latched.
  always_comb begin
    step_dout  = dout_q;
    step_carry = carry_q;
    case (mode_q)
      3'b000: begin
        step_dout  = {dout_q[WIDTH-2:0], bus.serial_in};
        step_carry = dout_q[WIDTH-1];
      end
      3'b001: begin
        step_dout  = {bus.serial_in, dout_q[WIDTH-1:1]};
        step_carry = dout_q[0];
      end
      3'b010: begin
        step_dout  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        step_carry = dout_q[WIDTH-1];
      end
      3'b011: begin
        step_dout  = {dout_q[0], dout_q[WIDTH-1:1]};
        step_carry = dout_q[0];
      end
`ifdef SEQ_SHIFTER_ARITH_EN
      3'b100: begin
        step_dout  = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
        step_carry = dout_q[0];
      end
`else
      3'b100: begin
        step_dout  = dout_q;
        step_carry = carry_q;
      end
`endif
      default: begin
        step_dout  = dout_q;
        step_carry = carry_q;
      end
    endcase
  end

  // Datapath: load on accepted start, step while shifting, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      mode_q  <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dout_q  <= bus.din;
            count_q <= bus.amt;
            mode_q  <= bus.mode;
            carry_q <= 1'b0;
          end
        end
        SHIFT: begin
          dout_q  <= step_dout;
          carry_q <= step_carry;
          count_q <= count_q - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers; busy/done decode the state register.
  assign bus.dout  = dout_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed self-checking bench for seq_shifter (WIDTH=4, AMT_W=3).
// Honours SEQ_SHIFTER_ARITH_EN for the mode 100 expectation.
module tb_seq_shifter;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   cyc;
  bit   done_seen;

  seq_shifter_if #(.WIDTH(4), .AMT_W(3)) sif ();

  seq_shifter #(.WIDTH(4), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one start, optionally inject a start with din=1111 on cycle
  // 'inject' of the operation, wait (bounded) for done and return the number
  // of negedges from the start edge to the done cycle (99 on timeout).
  task automatic do_op(input logic [3:0] d, input logic [2:0] m, input logic [2:0] a,
                       input logic si, input int inject, output int cycles);
    @(negedge clk);
    sif.start     = 1'b1;
    sif.din       = d;
    sif.mode      = m;
    sif.amt       = a;
    sif.serial_in = si;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.din   = 4'b0000;
    sif.amt   = 3'd0;
    sif.mode  = 3'b000;
    cycles = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == inject) begin
        sif.start = 1'b1;
        sif.din   = 4'b1111;
        sif.amt   = 3'd1;
      end else begin
        sif.start = 1'b0;
        sif.din   = 4'b0000;
      end
      if (sif.done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    sif.start = 1'b0;
  endtask

  // Check result on the done cycle, then that done drops and busy clears.
  task automatic check_op(input string tag, input int cycles, input int exp_cycles,
                          input logic [3:0] exp_dout, input logic exp_carry);
    chk({tag, "_latency"}, cycles, exp_cycles);
    chk({tag, "_dout"}, sif.dout, exp_dout);
    chk({tag, "_carry"}, sif.carry, exp_carry);
    chk({tag, "_busy_in_done"}, sif.busy, 1'b1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, sif.done, 1'b0);
    chk({tag, "_idle"}, sif.busy, 1'b0);
    chk({tag, "_hold_dout"}, sif.dout, exp_dout);
  endtask

  initial begin
    int n;
    logic [3:0] arith_exp;
    tests_run    = 0;
    tests_failed = 0;
    sif.start     = 1'b0;
    sif.mode      = 3'b000;
    sif.amt       = 3'd0;
    sif.din       = 4'b0000;
    sif.serial_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", sif.dout, 4'b0000);
    chk("rst_carry", sif.carry, 1'b0);
    chk("rst_busy", sif.busy, 1'b0);
    chk("rst_done", sif.done, 1'b0);
    chk("rst_state", sif.state, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a long shift.
    sif.start = 1'b1; sif.din = 4'b1111; sif.mode = 3'b000; sif.amt = 3'd7; sif.serial_in = 1'b0;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    chk("midrst_busy_before", sif.busy, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", sif.dout, 4'b0000);
    chk("midrst_carry", sif.carry, 1'b0);
    chk("midrst_busy", sif.busy, 1'b0);
    chk("midrst_done", sif.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (sif.done === 1'b1) done_seen = 1'b1;
    end
    chk("midrst_no_done", done_seen, 1'b0);

    // Logical right.
    do_op(4'b1001, 3'b001, 3'd2, 1'b0, 0, n);
    check_op("lsr2", n, 3, 4'b0010, 1'b0);
    do_op(4'b1001, 3'b001, 3'd1, 1'b0, 0, n);
    check_op("lsr1", n, 2, 4'b0100, 1'b1);

    // Rotate right wrapping past WIDTH, with an ignored start mid-operation.
    do_op(4'b1100, 3'b011, 3'd5, 1'b0, 2, n);
    check_op("ror5", n, 6, 4'b0110, 1'b0);

    // Left saturate and zero amount.
    do_op(4'b1111, 3'b000, 3'd4, 1'b0, 0, n);
    check_op("lsl4", n, 5, 4'b0000, 1'b1);
    do_op(4'b1011, 3'b000, 3'd0, 1'b0, 0, n);
    check_op("amt0", n, 1, 4'b1011, 1'b0);

    // serial_in fill on left shift.
    do_op(4'b0000, 3'b000, 3'd2, 1'b1, 0, n);
    check_op("lsl_fill", n, 3, 4'b0011, 1'b0);

    // Rotate left leaves carry=1; the following hold op must clear it on start.
    do_op(4'b1000, 3'b010, 3'd1, 1'b0, 0, n);
    check_op("rol1", n, 2, 4'b0001, 1'b1);
    do_op(4'b0101, 3'b111, 3'd3, 1'b1, 0, n);
    check_op("hold111", n, 4, 4'b0101, 1'b0);

    // Mode 100: arithmetic right when enabled, hold otherwise.
`ifdef SEQ_SHIFTER_ARITH_EN
    arith_exp = 4'b1110;
`else
    arith_exp = 4'b1000;
`endif
    do_op(4'b1000, 3'b100, 3'd2, 1'b0, 0, n);
    check_op("mode100", n, 3, arith_exp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
